// File: rtl/regheap_pkg.sv
// Shared constants and types for the RegHeap writeback arbiter.
package regheap_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic [0:0] {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regheap_scoreboard.sv
// Pending-write scoreboard: one bit per register for results still owed by
// the long-latency unit, plus the decode-side busy lookups.
module regheap_scoreboard #(
  parameter int ADDR_W = regheap_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              rd1_busy,
  output logic              rd2_busy
);
  import regheap_pkg::*;

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Next pending vector: clear first, then set, so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en && (clr_reg != ZERO_ADDR)) pending_nxt[clr_reg] = 1'b0;
    if (set_en && (set_reg != ZERO_ADDR)) pending_nxt[set_reg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending bits register; lost on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // Busy also covers the cycle where the write sits on the RegHeap port.
  always_comb begin
    rd1_busy = (rd1_addr != ZERO_ADDR) &&
               (pending[rd1_addr] || (reg_write && (write_reg == rd1_addr)));
    rd2_busy = (rd2_addr != ZERO_ADDR) &&
               (pending[rd2_addr] || (reg_write && (write_reg == rd2_addr)));
  end

endmodule

// File: rtl/regheap_wb_arbiter.sv
// Arbitrates the single RegHeap write port between the main pipeline (A)
// and a long-latency unit (B), with a starvation guard for B.
//
// state   | meaning
// PRI_A   | A has priority; B waits while A writes
// FORCE_B | one-cycle stall of A so a starved B gets the port
module regheap_wb_arbiter #(
  parameter int DATA_W     = regheap_pkg::DATA_W,
  parameter int ADDR_W     = regheap_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              stall_req,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);
  import regheap_pkg::*;

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STARVE_MAX - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  arb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             a_eff;
  logic             b_acc;
  logic             b_blocked;

  // stall_req comes straight from the state flop, so it is registered.
  assign stall_req = (state == FORCE_B);
  assign a_eff     = a_valid && (a_reg != ZERO_ADDR) && !stall_req;
  assign b_ready   = rst_n && (stall_req || !a_eff);
  assign b_acc     = b_valid && b_ready;
  assign b_blocked = b_valid && !b_ready;

  // Starvation FSM: force one B slot after STARVE_MAX blocked cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PRI_A;
    end else begin
      case (state)
        PRI_A:   if (b_blocked && (wait_cnt == CNT_LAST)) state <= FORCE_B;
        FORCE_B: state <= PRI_A;
        default: state <= PRI_A;
      endcase
    end
  end

  // Saturating count of consecutive blocked B cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!b_valid || b_acc) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_LAST) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Registered RegHeap write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (a_eff) begin
      regWrite  <= 1'b1;
      writeReg  <= a_reg;
      writeData <= a_data;
    end else if (b_acc && (b_reg != ZERO_ADDR)) begin
      regWrite  <= 1'b1;
      writeReg  <= b_reg;
      writeData <= b_data;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  regheap_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue_valid),
    .set_reg   (issue_reg),
    .clr_en    (b_acc),
    .clr_reg   (b_reg),
    .reg_write (regWrite),
    .write_reg (writeReg),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .rd1_busy  (rd1_busy),
    .rd2_busy  (rd2_busy)
  );

endmodule

// File: doc/regheap_wb_arbiter.md
Name: regheap_wb_arbiter

Overview:
- Shares the single RegHeap write port between two writeback sources:
  - A: main pipeline writeback. Always presented, never back-pressured except via stall_req.
  - B: long-latency unit such as mul/div. Uses a valid/ready handshake.
- Adds a starvation guard and a pending-write scoreboard, so decode can flag reads of registers not yet written.
- Registered outputs drive RegHeap's regWrite/writeReg/writeData directly.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (2**ADDR_W registers; register 0 is hardwired zero)
- STARVE_MAX, 4, number of consecutive blocked B cycles before A is stalled for one cycle (must be >= 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  A write request
- a_reg  in  ADDR_W  A destination
- a_data  in  DATA_W  A data
- b_valid  in  1  B write request; held until accepted
- b_ready  out  1  B accepted this cycle when b_valid && b_ready
- b_reg  in  ADDR_W  B destination
- b_data  in  DATA_W  B data
- issue_valid  in  1  B-unit op issued; reserves issue_reg
- issue_reg  in  ADDR_W  register reserved by issue
- rd1_addr  in  ADDR_W  decode read address 1
- rd2_addr  in  ADDR_W  decode read address 2
- rd1_busy  out  1  rd1_addr value not yet valid in RegHeap
- rd2_busy  out  1  rd2_addr value not yet valid in RegHeap
- stall_req  out  1  pipeline must hold A for this cycle
- regWrite  out  1  to RegHeap
- writeReg  out  ADDR_W  to RegHeap
- writeData  out  DATA_W  to RegHeap

Behaviour:
- Synchronous reset (rst_n=0 at posedge clk) clears:
  - regWrite=0, writeReg=0, writeData=0, stall_req=0
  - FSM=PRI_A, wait counter=0, scoreboard all 0
- b_ready is combinational and is 0 whenever rst_n=0.
- An A request is effective only if a_valid && a_reg!=0 && !stall_req.
  - A with a_reg==0 is dropped and does not occupy the port.
  - While stall_req=1, A is ignored; the pipeline re-presents it next cycle.
- b_ready = rst_n && (stall_req || !A effective).
- Latency: an accepted request appears on regWrite/writeReg/writeData at the next posedge (1 cycle). RegHeap commits it on the following edge.
  - If the winner targets reg 0 (B only), or there is no winner, the next cycle has regWrite=0; writeReg/writeData hold their previous values.
- Priority: A over B, except in state FORCE_B.
- Wait counter:
  - Increments (saturating at STARVE_MAX-1) on each cycle with b_valid && !b_ready.
  - Clears on B acceptance or when b_valid=0.
- FSM:
  - PRI_A -> FORCE_B when b_valid && !b_ready && counter==STARVE_MAX-1. With STARVE_MAX=1, the first blocked cycle triggers it.
  - FORCE_B -> PRI_A unconditionally after 1 cycle.
  - stall_req = (state==FORCE_B), registered.
  - In FORCE_B, b_ready=1. If b_valid=0 there (protocol violation), no write occurs and the FSM still returns to PRI_A.
- Scoreboard: one pending bit per register; bit 0 is always 0.
  - Set on issue_valid && issue_reg!=0.
  - Cleared on B acceptance with b_reg!=0.
  - Same-cycle set and clear of the same register: set wins.
  - A writes never clear pending bits.
- rdN_busy (combinational) = rdN_addr!=0 && (pending[rdN_addr] || (regWrite && writeReg==rdN_addr)). This covers the in-flight write cycle.
- Reset mid-operation: a pending B is not accepted; the B unit must re-present after reset; the scoreboard is lost.

Decomposition:
- Package regheap_pkg holds:
  - DATA_W, ADDR_W, REG_ZERO constant
  - state enum {PRI_A, FORCE_B}
  - write-request struct {valid, reg, data}
- One sub-module, regheap_scoreboard: pending bits, set/clear logic and the two busy lookups.
- The arbiter FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then no requests -> all outputs 0, b_ready=1 when rst_n=1.
- A only: a_valid=1, a_reg=3, a_data=32'hBBBB_BBBB -> next cycle regWrite=1, writeReg=3, writeData=BBBB_BBBB; rd1_addr=3 busy=1 that cycle only.
- Conflict: A continuous to regs 1..8; B valid at reg 9 with data 32'h1234_5678, STARVE_MAX=4:
  - b_ready=0 for 4 cycles, then stall_req=1 with b_ready=1.
  - Next cycle writeReg=9; A resumes afterwards with no A write lost.
- A to reg 0 plus B to reg 5 in the same cycle -> B accepted immediately; reg 0 is never written.
- Scoreboard: issue_reg=7, then rd2_addr=7 -> rd2_busy=1 until B accepted for reg 7 plus 1 cycle. Issue and accept of reg 7 in the same cycle -> stays busy.
- Reset mid-starvation (counter=2, b_valid=1) -> counter=0, FSM=PRI_A, scoreboard cleared, no write.
